// File: rtl/ctu_synch_ratio_fifo.sv
// Ratioed-clock crossing FIFO on cmp_clk: writes qualified by wr_sync, reads by rd_sync,
// with occupancy flags, sticky overflow and a synchronous flush.
module ctu_synch_ratio_fifo #(
  parameter int SIZE  = 1,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             cmp_clk,
  input  logic             arst_l,
  input  logic             wr_sync,
  input  logic             wr_vld,
  input  logic [SIZE-1:0]  presyncdata,
  input  logic             rd_sync,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic [SIZE-1:0]  syncdata,
  output logic             syncvld,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [SIZE-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  // Transfer qualification; a pop frees the slot a same-cycle push takes when full.
  always_comb begin
    pop_s  = rd_sync & rd_en & ~empty & ~flush;
    push_s = wr_sync & wr_vld & ~flush & (~full | pop_s);
    drop_s = wr_sync & wr_vld & ~flush & full & ~pop_s;
  end

  // Next occupancy.
  always_comb begin
    count_nxt_s = count;
    if (flush) begin
      count_nxt_s = {(PTR_W+1){1'b0}};
    end else if (push_s && !pop_s) begin
      count_nxt_s = count + (PTR_W+1)'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count - (PTR_W+1)'(1);
    end else begin
      count_nxt_s = count;
    end
  end

  // Pointers, occupancy flags and sticky overflow.
  always_ff @(posedge cmp_clk or negedge arst_l) begin
    if (!arst_l) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count    <= {(PTR_W+1){1'b0}};
      empty    <= 1'b1;
      full     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      count <= count_nxt_s;
      empty <= (count_nxt_s == {(PTR_W+1){1'b0}});
      full  <= (count_nxt_s == DEPTH_CNT);
      if (flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      // Drop takes priority so a coincident clear never hides a lost write.
      if (drop_s) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Output register, frozen between rd_sync pulses.
  always_ff @(posedge cmp_clk or negedge arst_l) begin
    if (!arst_l) begin
      syncdata <= {SIZE{1'b0}};
      syncvld  <= 1'b0;
    end else begin
      if (flush) begin
        syncvld <= 1'b0;
      end else if (rd_sync) begin
        syncvld <= pop_s;
      end
      if (pop_s) syncdata <= mem_r[rd_ptr_r];
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge cmp_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= presyncdata;
  end

endmodule

// File: tb/tb_ctu_synch_ratio_fifo.sv
// Scoreboard bench for ctu_synch_ratio_fifo: queue-based reference model, decoupled monitor.
module tb_ctu_synch_ratio_fifo;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic            cmp_clk = 1'b0;
  logic            arst_l  = 1'b0;
  logic            wr_sync = 1'b0;
  logic            wr_vld  = 1'b0;
  logic [SIZE-1:0] presyncdata = '0;
  logic            rd_sync = 1'b0;
  logic            rd_en   = 1'b0;
  logic            flush   = 1'b0;
  logic            ovf_clr = 1'b0;
  logic [SIZE-1:0] syncdata;
  logic            syncvld;
  logic [PTR_W:0]  count;
  logic            empty;
  logic            full;
  logic            ovf;

  ctu_synch_ratio_fifo #(.SIZE(SIZE), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .cmp_clk(cmp_clk), .arst_l(arst_l), .wr_sync(wr_sync), .wr_vld(wr_vld),
    .presyncdata(presyncdata), .rd_sync(rd_sync), .rd_en(rd_en), .flush(flush),
    .ovf_clr(ovf_clr), .syncdata(syncdata), .syncvld(syncvld), .count(count),
    .empty(empty), .full(full), .ovf(ovf)
  );

  always #5 cmp_clk = ~cmp_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [SIZE-1:0] model_q [$];
  logic [SIZE-1:0] exp_q [$];
  logic            m_vld = 1'b0;
  logic            m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Reference model: plain FIFO queue following the push/pop/drop rules.
  always @(posedge cmp_clk or negedge arst_l) begin
    int sz;
    logic pop_m, push_m, drop_m;
    if (!arst_l) begin
      model_q.delete();
      exp_q.delete();
      m_vld = 1'b0;
      m_ovf = 1'b0;
    end else begin
      sz     = model_q.size();
      pop_m  = rd_sync && rd_en && (sz > 0) && !flush;
      push_m = wr_sync && wr_vld && !flush && ((sz < DEPTH) || pop_m);
      drop_m = wr_sync && wr_vld && !flush && (sz == DEPTH) && !pop_m;
      if (pop_m) exp_q.push_back(model_q.pop_front());
      if (push_m) model_q.push_back(presyncdata);
      if (flush) begin
        model_q.delete();
        m_vld = 1'b0;
      end else if (rd_sync) begin
        m_vld = pop_m;
      end
      if (drop_m) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a newly read entry.
  initial begin
    logic            saw_rd;
    logic [SIZE-1:0] hold_sd;
    saw_rd  = 1'b0;
    hold_sd = '0;
    forever begin
      @(posedge cmp_clk);
      saw_rd = rd_sync && arst_l;
      @(negedge cmp_clk);
      if (!arst_l) begin
        hold_sd = '0;
        saw_rd  = 1'b0;
      end
      chk("syncvld", 32'(syncvld), 32'(m_vld));
      chk("count",   32'(count),   32'(model_q.size()));
      chk("empty",   32'(empty),   32'(model_q.size() == 0));
      chk("full",    32'(full),    32'(model_q.size() == DEPTH));
      chk("ovf",     32'(ovf),     32'(m_ovf));
      if (saw_rd && syncvld === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          hold_sd = exp_q.pop_front();
          chk("syncdata_pop", 32'(syncdata), 32'(hold_sd));
        end
      end else begin
        chk("syncdata_hold", 32'(syncdata), 32'(hold_sd));
      end
    end
  end

  task automatic drive(input logic ws, input logic wv, input logic [SIZE-1:0] d,
                       input logic rs, input logic re, input logic fl, input logic oc);
    @(negedge cmp_clk);
    #1;
    wr_sync = ws; wr_vld = wv; presyncdata = d;
    rd_sync = rs; rd_en = re; flush = fl; ovf_clr = oc;
  endtask

  task automatic push(input logic [SIZE-1:0] d); drive(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();  drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic idle(); drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  initial begin
    int wcnt;
    repeat (3) idle();
    @(negedge cmp_clk); #1; arst_l = 1'b1;

    // Reset mid-burst with three entries held.
    push(8'h11); push(8'h22); push(8'h33);
    push(8'h44);
    #2 arst_l = 1'b0;
    repeat (2) idle();
    @(negedge cmp_clk); #1; arst_l = 1'b1;
    idle();

    // Basic latency and hold.
    push(8'hA5); pop();
    repeat (3) idle();

    // Fill, overflow and clear.
    for (int i = 1; i <= 5; i++) push(8'(i));
    idle();
    repeat (4) pop();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    drive(1'b1, 1'b1, 8'h2F, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous push/pop while full, then while empty.
    drive(1'b1, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) pop();
    drive(1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    pop();

    // Pointer wrap.
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h40 + i));
      pop();
    end

    // Flush with push and pop coinciding.
    push(8'h61); push(8'h62); push(8'h63);
    drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    push(8'h88); pop();
    idle();

    // Ratioed rates: writes every 4 cycles, reads every 3.
    wcnt = 0;
    for (int c = 0; wcnt < 200; c++) begin
      drive((c % 4) == 0, 1'b1, 8'($urandom), (c % 3) == 0, 1'b1, 1'b0, 1'b0);
      if ((c % 4) == 0) wcnt++;
    end
    for (int c = 0; c < 12; c++) drive(1'b0, 1'b0, 8'h00, (c % 3) == 0, 1'b1, 1'b0, 1'b0);

    // Random mix including flush and ovf_clr.
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
    end
    repeat (3) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
